// File: rtl/psum_accumulator.sv
// psum_accumulator: resolves sum/carry vector pairs and accumulates them into saturating psums with valid/ready output
module psum_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int PSUM_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_sum,
    input  logic [DATA_WIDTH-1:0] in_carry,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LEN_WIDTH-1:0]  acc_len,
    output logic [PSUM_WIDTH-1:0] psum_out,
    output logic                  psum_valid,
    input  logic                  psum_ready,
    output logic                  psum_ovf,
    output logic                  busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [PSUM_WIDTH-1:0] acc_q, acc_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d, len_q, len_d, len_new, cnt_nx;
    logic                  ovf_q, ovf_d;
    logic [PSUM_WIDTH-1:0] v;
    logic [PSUM_WIDTH:0]   sum_w;
    logic                  accept;

    assign v        = PSUM_WIDTH'(in_sum) + (PSUM_WIDTH'(in_carry) << 1);
    assign sum_w    = {1'b0, acc_q} + {1'b0, v};
    assign in_ready = state_q != HOLD;
    assign accept   = in_valid & in_ready;
    assign len_new  = acc_len == '0 ? LEN_WIDTH'(1) : acc_len;
    assign cnt_nx   = cnt_q + 1'b1;

    assign psum_valid = state_q == HOLD;
    assign psum_out   = psum_valid ? acc_q : '0;
    assign psum_ovf   = psum_valid & ovf_q;
    assign busy       = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && accept) begin
            len_d   = len_new;
            acc_d   = v;
            cnt_d   = LEN_WIDTH'(1);
            ovf_d   = 1'b0;
            state_d = len_new == LEN_WIDTH'(1) ? HOLD : ACCUM;
        end else if (state_q == ACCUM && accept) begin
            acc_d   = sum_w[PSUM_WIDTH] ? '1 : sum_w[PSUM_WIDTH-1:0];
            ovf_d   = ovf_q | sum_w[PSUM_WIDTH];
            cnt_d   = cnt_nx;
            state_d = cnt_nx == len_q ? HOLD : ACCUM;
        end else if (state_q == HOLD && psum_ready) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed and random checks of psum_accumulator (18-bit psum for saturation reach)
module tb_psum_accumulator;
    localparam int DW = 16;
    localparam int PW = 18;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_sum = '0, in_carry = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LW-1:0] acc_len = '0;
    logic [PW-1:0] psum_out;
    logic          psum_valid;
    logic          psum_ready = 1'b1;
    logic          psum_ovf;
    logic          busy;
    int            total = 0, bad = 0;

    psum_accumulator #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .in_sum(in_sum), .in_carry(in_carry),
        .in_valid(in_valid), .in_ready(in_ready), .acc_len(acc_len),
        .psum_out(psum_out), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .psum_ovf(psum_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] s, input logic [DW-1:0] c);
        int n = 0;
        in_sum = s;
        in_carry = c;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic logic [PW-1:0] sat_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW:0] t = {1'b0, a} + {1'b0, b};
        return t[PW] ? {PW{1'b1}} : t[PW-1:0];
    endfunction

    initial begin
        logic [PW-1:0] exp, held;
        logic          eovf;
        int            len;
        logic [DW-1:0] s, c;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_valid", psum_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out", psum_out, 0);

        // async reset mid-accumulation
        acc_len = 4;
        push(16'd7, 16'd7);
        push(16'd1, 16'd0);
        chk("acc_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", psum_valid, 0);
        chk("arst_out", psum_out, 0);
        chk("arst_ovf", psum_ovf, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("arst_ready", in_ready, 1);

        // basic: 7 + 3 + 4
        acc_len = 3;
        push(16'd5, 16'd1);
        push(16'd3, 16'd0);
        chk("basic_novalid", psum_valid, 0);
        push(16'd0, 16'd2);
        chk("basic_valid", psum_valid, 1);
        chk("basic_out", psum_out, 14);
        chk("basic_ovf", psum_ovf, 0);
        @(negedge clk);
        chk("basic_one_cycle", psum_valid, 0);
        chk("basic_idle", busy, 0);

        // bubbles and backpressure
        psum_ready = 1'b0;
        acc_len = 4;
        push(16'd1, 16'd0);
        @(negedge clk);
        push(16'd2, 16'd0);
        @(negedge clk);
        @(negedge clk);
        push(16'd3, 16'd0);
        push(16'd4, 16'd0);
        in_sum = 16'd100;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", psum_valid, 1);
            chk("bp_out", psum_out, 10);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        psum_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_release", psum_valid, 0);
        chk("bp_ready", in_ready, 1);
        chk("bp_busy", busy, 0);

        // length edges
        acc_len = 0;
        push(16'd9, 16'd0);
        chk("len0_valid", psum_valid, 1);
        chk("len0_out", psum_out, 9);
        @(negedge clk);
        acc_len = 1;
        push(16'd9, 16'd0);
        chk("len1_valid", psum_valid, 1);
        chk("len1_out", psum_out, 9);
        @(negedge clk);
        acc_len = 2;
        push(16'd1, 16'd1);
        acc_len = 1;
        @(negedge clk);
        chk("lenchg_novalid", psum_valid, 0);
        push(16'd2, 16'd0);
        chk("lenchg_valid", psum_valid, 1);
        chk("lenchg_out", psum_out, 5);
        @(negedge clk);

        // saturation then clean psum
        acc_len = 5;
        for (int i = 0; i < 5; i++) push(16'hFFFF, 16'hFFFF);
        chk("sat_out", psum_out, 32'h3FFFF);
        chk("sat_ovf", psum_ovf, 1);
        @(negedge clk);
        acc_len = 1;
        push(16'd1, 16'd0);
        chk("post_sat_out", psum_out, 1);
        chk("post_sat_ovf", psum_ovf, 0);
        @(negedge clk);

        // random streams with bubbles and backpressure
        psum_ready = 1'b0;
        for (int p = 0; p < 20; p++) begin
            len = $urandom_range(1, 5);
            acc_len = LW'(len);
            exp = '0;
            eovf = 1'b0;
            for (int k = 0; k < len; k++) begin
                s = DW'($urandom_range(0, 65535));
                c = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 65535)) : DW'($urandom_range(0, 255));
                held = PW'(s) + (PW'(c) << 1);
                if (k == 0) exp = held;
                else begin
                    eovf = eovf | ({1'b0, exp} + {1'b0, held} > {1'b0, {PW{1'b1}}});
                    exp = sat_add(exp, held);
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if (k == 1) acc_len = LW'($urandom_range(0, 9));
                push(s, c);
            end
            chk("rnd_valid", psum_valid, 1);
            chk("rnd_out", psum_out, exp);
            chk("rnd_ovf", psum_ovf, eovf);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("rnd_hold_out", psum_out, exp);
                chk("rnd_hold_rdy", in_ready, 0);
            end
            psum_ready = 1'b1;
            @(negedge clk);
            psum_ready = 1'b0;
            chk("rnd_done", psum_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
